// File: rtl/vga_timing_gen.sv
// Raster timing source: DrawX/DrawY, blank, active-low hs/vs, frame strobe, animation step index.
// Latency: every output is registered from the pre-edge counters (1 cycle), all mutually aligned.
// Backpressure: none; free-running on every vga_clk edge, anim_en only gates the animation divider.
module vga_timing_gen #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int ANIM_DIV    = 6,
    parameter int ANIM_FRAMES = 4
) (
    input  logic                           vga_clk,
    input  logic                           reset_n,
    input  logic                           anim_en,
    output logic                           hs,
    output logic                           vs,
    output logic                           blank,
    output logic [9:0]                     DrawX,
    output logic [9:0]                     DrawY,
    output logic                           frame_start,
    output logic [$clog2(ANIM_FRAMES)-1:0] anim_frame
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // All counter comparisons are done against 10-bit constants so widths match exactly.
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    // Divider is at least 3 bits wide; it only needs to reach ANIM_DIV-1.
    localparam int DIV_W = ($clog2(ANIM_DIV) > 3) ? $clog2(ANIM_DIV) : 3;
    localparam int AW    = $clog2(ANIM_FRAMES);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(ANIM_DIV - 1);
    localparam logic [AW-1:0]    ANIM_LAST = AW'(ANIM_FRAMES - 1);

    logic [9:0]       hc_q, hc_d;
    logic [9:0]       vc_q, vc_d;
    logic [9:0]       x_q, y_q;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             blank_q, blank_d;
    logic             fs_q, fs_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [AW-1:0]    anim_q, anim_d;

    // Raster counters: hc wraps every line, vc steps only on the hc wrap.
    always_comb begin
        hc_d = hc_q + 10'd1;
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            hc_d = '0;
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
        end
    end

    // Decode the pre-edge position into next-cycle blank, syncs and frame strobe.
    always_comb begin
        blank_d = (hc_q < H_VIS) && (vc_q < V_VIS);
        hs_d    = !((hc_q >= HS_START) && (hc_q < HS_END));
        vs_d    = !((vc_q >= VS_START) && (vc_q < VS_END));
        fs_d    = (hc_q == '0) && (vc_q == '0);
    end

    // Animation divider advances only on the edge that registers frame_start, so
    // anim_frame is constant across the whole frame that follows.
    always_comb begin
        div_d  = div_q;
        anim_d = anim_q;
        if (fs_d && anim_en) begin
            if (div_q == DIV_LAST) begin
                div_d  = '0;
                anim_d = (anim_q == ANIM_LAST) ? '0 : anim_q + AW'(1);
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    // State and output registers; reset forces the idle (blanked, syncs high) raster origin.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc_q    <= '0;
            vc_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            fs_q    <= 1'b0;
            div_q   <= '0;
            anim_q  <= '0;
        end else begin
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            x_q     <= hc_q;
            y_q     <= vc_q;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            fs_q    <= fs_d;
            div_q   <= div_d;
            anim_q  <= anim_d;
        end
    end

    assign hs          = hs_q;
    assign vs          = vs_q;
    assign blank       = blank_q;
    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign frame_start = fs_q;
    assign anim_frame  = anim_q;

endmodule
